// File: rtl/stopwatch_pkg.sv
// Shared state encoding and display-range limits for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RUN_LAP = 2'd2,
    PAUSE   = 2'd3
  } state_t;

  localparam int CS_MAX  = 99;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

endpackage

// File: rtl/time_counter.sv
// mm:ss.cc cascade counter with clear, single-step increment and a wrap pulse
// that fires combinationally on the increment that rolls 59:59.99 to zero.
module time_counter
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [6:0] centiseconds,
  output logic       wrap
);

  logic cs_top;
  logic sec_top;
  logic min_top;

  assign cs_top  = (centiseconds == 7'(CS_MAX));
  assign sec_top = (seconds == 6'(SEC_MAX));
  assign min_top = (minutes == 6'(MIN_MAX));
  assign wrap    = inc && cs_top && sec_top && min_top;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      minutes      <= '0;
      seconds      <= '0;
      centiseconds <= '0;
    end else if (inc) begin
      if (!cs_top) begin
        centiseconds <= centiseconds + 7'd1;
      end else begin
        centiseconds <= '0;
        if (!sec_top) begin
          seconds <= seconds + 6'd1;
        end else begin
          seconds <= '0;
          minutes <= min_top ? 6'd0 : minutes + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch FSM with prescaled tick, lap freeze and sticky overflow; the display
// shows the frozen lap value in RUN_LAP and the live count otherwise.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [6:0] centiseconds,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  // DIV must be at least 2 so the prescaler has a distinct terminal value.
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TOP = PW'(DIV - 1);

  state_t        state;
  logic [PW-1:0] prescaler;
  logic          counting;
  logic          tick;
  logic          wrap;
  logic [5:0]    live_min;
  logic [5:0]    live_sec;
  logic [6:0]    live_cs;
  logic [5:0]    lap_min;
  logic [5:0]    lap_sec;
  logic [6:0]    lap_cs;

  assign counting = (state == RUN) || (state == RUN_LAP);
  assign tick     = counting && (prescaler == TOP);

  time_counter u_live (
    .clk          (clk),
    .rst          (rst),
    .clr          (btn_clear),
    .inc          (tick),
    .minutes      (live_min),
    .seconds      (live_sec),
    .centiseconds (live_cs),
    .wrap         (wrap)
  );

  // Clear beats start_stop, which beats lap; the prescaler only advances while running.
  always_ff @(posedge clk) begin
    if (rst || btn_clear) begin
      state      <= IDLE;
      prescaler  <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
      lap_min    <= '0;
      lap_sec    <= '0;
      lap_cs     <= '0;
    end else begin
      if (counting) prescaler <= tick ? '0 : prescaler + PW'(1);
      if (wrap) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (btn_start_stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (btn_start_stop) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (btn_lap) begin
            state      <= RUN_LAP;
            lap_active <= 1'b1;
            lap_min    <= live_min;
            lap_sec    <= live_sec;
            lap_cs     <= live_cs;
          end
        end
        RUN_LAP: begin
          if (btn_start_stop) begin
            state      <= PAUSE;
            running    <= 1'b0;
            lap_active <= 1'b0;
          end else if (btn_lap) begin
            state      <= RUN;
            lap_active <= 1'b0;
          end
        end
        PAUSE: begin
          if (btn_start_stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign minutes      = lap_active ? lap_min : live_min;
  assign seconds      = lap_active ? lap_sec : live_sec;
  assign centiseconds = lap_active ? lap_cs  : live_cs;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller at CLK_FREQ=1000, TICK_HZ=100 (DIV=10);
// inputs change and outputs are sampled on the falling edge.
module tb_stopwatch_controller;

  logic       clk;
  logic       rst;
  logic       btn_start_stop;
  logic       btn_lap;
  logic       btn_clear;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [6:0] centiseconds;
  logic       running;
  logic       lap_active;
  logic       overflow;

  int check_count;
  int error_count;

  stopwatch_controller #(
    .CLK_FREQ (1000),
    .TICK_HZ  (100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .minutes        (minutes),
    .seconds        (seconds),
    .centiseconds   (centiseconds),
    .running        (running),
    .lap_active     (lap_active),
    .overflow       (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Holds the given buttons for exactly one rising edge.
  task automatic applyStimulus(input logic ss, input logic lap, input logic clr);
    btn_start_stop = ss;
    btn_lap        = lap;
    btn_clear      = clr;
    @(negedge clk);
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
  endtask

  task automatic checkTime(input string tag, input int m, input int s, input int cs);
    checkOutput({tag, ".min"}, int'(minutes), m);
    checkOutput({tag, ".sec"}, int'(seconds), s);
    checkOutput({tag, ".cs"}, int'(centiseconds), cs);
  endtask

  task automatic presetLive(input int m, input int s, input int cs);
    force dut.u_live.minutes      = 6'(m);
    force dut.u_live.seconds      = 6'(s);
    force dut.u_live.centiseconds = 7'(cs);
    #1;
    release dut.u_live.minutes;
    release dut.u_live.seconds;
    release dut.u_live.centiseconds;
  endtask

  initial begin
    check_count    = 0;
    error_count    = 0;
    rst            = 1'b1;
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
    waitClocks(2);
    checkTime("reset", 0, 0, 0);
    checkOutput("reset.running", int'(running), 0);
    checkOutput("reset.lap_active", int'(lap_active), 0);
    checkOutput("reset.overflow", int'(overflow), 0);
    rst = 1'b0;

    // 250 clocks in RUN -> 25 ticks
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitClocks(250);
    checkTime("run250", 0, 0, 25);
    checkOutput("run250.running", int'(running), 1);

    // Seconds-to-minutes carry
    presetLive(0, 59, 50);
    waitClocks(490);
    checkTime("pre_min", 0, 59, 99);
    waitClocks(10);
    checkTime("min_carry", 1, 0, 0);
    checkOutput("min_carry.overflow", int'(overflow), 0);

    // Full wrap sets sticky overflow; clear drops it
    presetLive(59, 59, 99);
    waitClocks(9);
    checkTime("pre_wrap", 59, 59, 99);
    checkOutput("pre_wrap.overflow", int'(overflow), 0);
    waitClocks(1);
    checkTime("wrap", 0, 0, 0);
    checkOutput("wrap.overflow", int'(overflow), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clear.overflow", int'(overflow), 0);
    checkOutput("clear.running", int'(running), 0);
    waitClocks(20);
    checkTime("idle_hold", 0, 0, 0);

    // Lap freeze at 00:03.40 while live count keeps running
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitClocks(3400);
    checkTime("at340", 0, 3, 40);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitClocks(100);
    checkTime("lap_hold", 0, 3, 40);
    checkOutput("lap_hold.lap_active", int'(lap_active), 1);
    checkOutput("lap_hold.running", int'(running), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkTime("lap_release", 0, 3, 50);
    checkOutput("lap_release.lap_active", int'(lap_active), 0);

    // Pause with prescaler at 7, then restart needs 3 more clocks to tick
    waitClocks(4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitClocks(500);
    checkTime("paused", 0, 3, 50);
    checkOutput("paused.running", int'(running), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitClocks(2);
    checkOutput("restart2.cs", int'(centiseconds), 50);
    waitClocks(1);
    checkOutput("restart3.cs", int'(centiseconds), 51);

    // start_stop coinciding with a tick at 00:00.09
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitClocks(99);
    checkOutput("pre_ss_tick.cs", int'(centiseconds), 9);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkTime("ss_tick", 0, 0, 10);
    checkOutput("ss_tick.running", int'(running), 0);
    waitClocks(30);
    checkOutput("ss_tick_hold.cs", int'(centiseconds), 10);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkTime("clr_ss", 0, 0, 0);
    checkOutput("clr_ss.running", int'(running), 0);
    waitClocks(20);
    checkOutput("clr_ss_idle.cs", int'(centiseconds), 0);

    // Lap coinciding with a tick captures the pre-increment value
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitClocks(9);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("lap_tick.cs", int'(centiseconds), 0);
    checkOutput("lap_tick.lap_active", int'(lap_active), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("lap_tick_live.cs", int'(centiseconds), 1);

    // Clear coinciding with a tick
    waitClocks(8);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clr_tick.cs", int'(centiseconds), 0);
    checkOutput("clr_tick.running", int'(running), 0);

    // Reset mid RUN_LAP on a tick edge
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitClocks(15);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitClocks(3);
    rst = 1'b1;
    waitClocks(1);
    checkTime("rst_lap", 0, 0, 0);
    checkOutput("rst_lap.lap_active", int'(lap_active), 0);
    checkOutput("rst_lap.running", int'(running), 0);
    rst = 1'b0;
    waitClocks(20);
    checkOutput("rst_lap_idle.cs", int'(centiseconds), 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
